// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks k and the valid i range, issuing x/y reads, MAC control and z writes.
// Optional cycle counter output cyc_cnt_o is enabled by defining CONV_SEQ_CYCLE_CNT_EN.
module conv_seq_ctrl #(
  parameter int unsigned AW_XY = 5,
  parameter int unsigned AW_Z  = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [AW_XY-1:0] sz_x_i,
  input  logic [AW_XY-1:0] sz_y_i,
  output logic [AW_XY-1:0] addr_x_o,
  output logic [AW_XY-1:0] addr_y_o,
  output logic             rd_o,
  output logic             acc_clr_o,
  output logic             acc_en_o,
  output logic [AW_Z-1:0]  addr_z_o,
  output logic             wr_z_o,
  output logic             busy_o,
  output logic             done_o
`ifdef CONV_SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0]      cyc_cnt_o
`endif
);

  typedef enum logic [2:0] {StIdle, StClr, StRead, StDrain, StWrite, StDone} state_e;

  localparam logic signed [AW_Z:0] SOne = (AW_Z+1)'(1);

  state_e           r_state;
  logic [AW_XY-1:0] r_sz_x, r_sz_y, r_i_hi, r_addr_x, r_addr_y;
  logic [AW_Z-1:0]  r_k, r_addr_z;
  logic             r_rd, r_acc_clr, r_acc_en, r_wr_z, r_busy, r_done;

  logic signed [AW_Z:0] w_k_s, w_szx_m1, w_szy_m1, w_lo_s, w_hi_s;
  logic [AW_XY-1:0]     w_i_lo, w_i_hi, w_y_lo;
  logic [AW_Z-1:0]      w_k_last;
  logic                 w_zero;

  // Valid product range for the current k: i in [max(0,k-(sy-1)), min(k,sx-1)].
  assign w_k_s    = $signed({1'b0, r_k});
  assign w_szx_m1 = $signed({{(AW_Z+1-AW_XY){1'b0}}, r_sz_x}) - SOne;
  assign w_szy_m1 = $signed({{(AW_Z+1-AW_XY){1'b0}}, r_sz_y}) - SOne;
  assign w_lo_s   = w_k_s - w_szy_m1;
  assign w_hi_s   = (w_k_s < w_szx_m1) ? w_k_s : w_szx_m1;
  assign w_i_lo   = w_lo_s[AW_Z] ? '0 : AW_XY'(w_lo_s);
  assign w_i_hi   = AW_XY'(w_hi_s);
  assign w_y_lo   = AW_XY'(r_k - AW_Z'(w_i_lo));
  assign w_k_last = AW_Z'(r_sz_x) + AW_Z'(r_sz_y) - AW_Z'(2);
  assign w_zero   = (sz_x_i == '0) || (sz_y_i == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_sz_x    <= '0;
      r_sz_y    <= '0;
      r_i_hi    <= '0;
      r_k       <= '0;
      r_addr_x  <= '0;
      r_addr_y  <= '0;
      r_addr_z  <= '0;
      r_rd      <= 1'b0;
      r_acc_clr <= 1'b0;
      r_acc_en  <= 1'b0;
      r_wr_z    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // Memory read latency is one cycle, so the product is ready a cycle after the read.
      r_acc_en <= r_rd;
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            r_sz_x <= sz_x_i;
            r_sz_y <= sz_y_i;
            r_k    <= '0;
            r_busy <= 1'b1;
            if (w_zero) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state   <= StClr;
              r_acc_clr <= 1'b1;
            end
          end
        end
        StClr: begin
          r_acc_clr <= 1'b0;
          r_i_hi    <= w_i_hi;
          r_addr_x  <= w_i_lo;
          r_addr_y  <= w_y_lo;
          r_rd      <= 1'b1;
          r_state   <= StRead;
        end
        StRead: begin
          if (r_addr_x == r_i_hi) begin
            r_rd    <= 1'b0;
            r_state <= StDrain;
          end else begin
            r_addr_x <= r_addr_x + AW_XY'(1);
            r_addr_y <= r_addr_y - AW_XY'(1);
          end
        end
        StDrain: begin
          r_wr_z   <= 1'b1;
          r_addr_z <= r_k;
          r_state  <= StWrite;
        end
        StWrite: begin
          r_wr_z <= 1'b0;
          if (r_k == w_k_last) begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_k       <= r_k + AW_Z'(1);
            r_acc_clr <= 1'b1;
            r_state   <= StClr;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign addr_x_o  = r_addr_x;
  assign addr_y_o  = r_addr_y;
  assign rd_o      = r_rd;
  assign acc_clr_o = r_acc_clr;
  assign acc_en_o  = r_acc_en;
  assign addr_z_o  = r_addr_z;
  assign wr_z_o    = r_wr_z;
  assign busy_o    = r_busy;
  assign done_o    = r_done;

`ifdef CONV_SEQ_CYCLE_CNT_EN
  logic [15:0] r_cyc_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cyc_cnt <= '0;
    end else if (r_state == StIdle && start_i) begin
      r_cyc_cnt <= '0;
    end else if (r_busy && r_cyc_cnt != 16'hFFFF) begin
      r_cyc_cnt <= r_cyc_cnt + 16'd1;
    end
  end

  assign cyc_cnt_o = r_cyc_cnt;
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: behavioural x/y memories and MAC, read/write order model, literal pins.
module tb_conv_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start_i = 1'b0;
  logic [4:0] sz_x_i = '0, sz_y_i = '0;
  logic [4:0] addr_x_o, addr_y_o;
  logic [5:0] addr_z_o;
  logic       rd_o, acc_clr_o, acc_en_o, wr_z_o, busy_o, done_o;
`ifdef CONV_SEQ_CYCLE_CNT_EN
  logic [15:0] cyc_cnt_o;
`endif

  conv_seq_ctrl #(.AW_XY(5), .AW_Z(6)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start_i   (start_i),
    .sz_x_i    (sz_x_i),
    .sz_y_i    (sz_y_i),
    .addr_x_o  (addr_x_o),
    .addr_y_o  (addr_y_o),
    .rd_o      (rd_o),
    .acc_clr_o (acc_clr_o),
    .acc_en_o  (acc_en_o),
    .addr_z_o  (addr_z_o),
    .wr_z_o    (wr_z_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
`ifdef CONV_SEQ_CYCLE_CNT_EN
    ,
    .cyc_cnt_o (cyc_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int x_mem[32];
  int y_mem[32];
  int tb_z[64];
  int exp_rx[$], exp_ry[$], exp_wz[$];
  int log_x[$], log_y[$];
  int exp_done, cyc, seen_done, n_rd, n_wr, last_wz;
  bit job_active = 1'b0;
  int xd, yd, acc;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural memories with one-cycle read, plus the MAC they feed.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xd  <= 0;
      yd  <= 0;
      acc <= 0;
    end else begin
      if (rd_o) begin
        xd <= x_mem[addr_x_o];
        yd <= y_mem[addr_y_o];
      end
      if (acc_clr_o) acc <= 0;
      else if (acc_en_o) acc <= acc + xd * yd;
    end
  end

  // Compare process: every cycle, mid-clock.
  always @(negedge clk) begin
    if (rstn) begin
      if (job_active) begin
        cyc++;
        check("busy_in_job", int'(busy_o), 1);
        if (rd_o) begin
          n_rd++;
          log_x.push_back(int'(addr_x_o));
          log_y.push_back(int'(addr_y_o));
          check("read_expected", int'(exp_rx.size() > 0), 1);
          if (exp_rx.size() > 0) begin
            check("addr_x", int'(addr_x_o), exp_rx.pop_front());
            check("addr_y", int'(addr_y_o), exp_ry.pop_front());
          end
        end
        if (wr_z_o) begin
          n_wr++;
          last_wz = int'(addr_z_o);
          tb_z[addr_z_o] = acc;
          check("write_expected", int'(exp_wz.size() > 0), 1);
          if (exp_wz.size() > 0) check("addr_z", int'(addr_z_o), exp_wz.pop_front());
        end
        if (done_o) begin
          seen_done = cyc;
          check("done_cycle", cyc, exp_done);
          check("reads_left", exp_rx.size(), 0);
          check("writes_left", exp_wz.size(), 0);
          job_active = 1'b0;
        end else if (cyc >= exp_done + 50) begin
          check("done_cycle", cyc, exp_done);
          job_active = 1'b0;
        end
      end else begin
        check("idle_outputs", int'({busy_o, rd_o, wr_z_o, done_o, acc_en_o, acc_clr_o}), 0);
      end
    end
  end

  task automatic prep(input int sx, input int sy, input bit ramp);
    for (int i = 0; i < 32; i++) begin
      x_mem[i] = ramp ? i + 1 : int'($urandom_range(0, 15));
      y_mem[i] = ramp ? i + 1 : int'($urandom_range(0, 15));
    end
    for (int i = 0; i < 64; i++) tb_z[i] = -1;
    exp_rx.delete(); exp_ry.delete(); exp_wz.delete();
    log_x.delete(); log_y.delete();
    if (sx > 0 && sy > 0) begin
      for (int k = 0; k <= sx + sy - 2; k++) begin
        for (int i = 0; i < sx; i++) begin
          if (k - i >= 0 && k - i < sy) begin
            exp_rx.push_back(i);
            exp_ry.push_back(k - i);
          end
        end
        exp_wz.push_back(k);
      end
    end
    exp_done = (sx == 0 || sy == 0) ? 1 : sx * sy + 3 * (sx + sy - 1) + 1;
    n_rd = 0; n_wr = 0; seen_done = 0; last_wz = -1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the edge that ends the done cycle.
  task automatic run_job(input int sx, input int sy, input bit ramp, input bit poke);
    int sum;
    prep(sx, sy, ramp);
    sz_x_i  = 5'(sx);
    sz_y_i  = 5'(sy);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 0;
    job_active = 1'b1;
    for (int n = 0; n < 4000 && job_active; n++) begin
      if (poke && n == 4) begin
        start_i = 1'b1;
        sz_x_i  = 5'd9;
        sz_y_i  = 5'd17;
      end
      if (poke && n == 5) start_i = 1'b0;
      @(posedge clk); #1;
    end
    if (job_active) begin
      check("job_timeout", cyc, exp_done);
      job_active = 1'b0;
    end
    check("read_count", n_rd, sx * sy);
    check("write_count", n_wr, (sx > 0 && sy > 0) ? sx + sy - 1 : 0);
    if (sx > 0 && sy > 0) begin
      for (int k = 0; k <= sx + sy - 2; k++) begin
        sum = 0;
        for (int i = 0; i < sx; i++)
          if (k - i >= 0 && k - i < sy) sum += x_mem[i] * y_mem[k - i];
        check("z_value", tb_z[k], sum);
      end
    end
`ifdef CONV_SEQ_CYCLE_CNT_EN
    check("cyc_cnt", int'(cyc_cnt_o), exp_done);
`endif
  endtask

  initial begin
    int lit_z[7];
    lit_z = '{1, 4, 10, 20, 25, 24, 16};

    #2;
    check("reset_strobes", int'({busy_o, rd_o, wr_z_o, done_o, acc_en_o, acc_clr_o}), 0);
    check("reset_addrs", int'({addr_x_o, addr_y_o, addr_z_o}), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    run_job(1, 1, 1'b1, 1'b0);
    check("lit_1x1_done", seen_done, 5);
    check("lit_1x1_z0", tb_z[0], 1);

    run_job(4, 4, 1'b1, 1'b0);
    check("lit_4x4_done", seen_done, 38);
    check("lit_4x4_reads", n_rd, 16);
    for (int k = 0; k < 7; k++) check("lit_4x4_z", tb_z[k], lit_z[k]);

    run_job(5, 2, 1'b0, 1'b0);
    check("lit_5x2_reads", n_rd, 10);
    check("lit_5x2_writes", n_wr, 6);
    check("lit_5x2_r5x", log_x[5], 2);
    check("lit_5x2_r5y", log_y[5], 1);
    check("lit_5x2_r6x", log_x[6], 3);
    check("lit_5x2_r6y", log_y[6], 0);
    check("lit_5x2_r9x", log_x[9], 4);
    check("lit_5x2_r9y", log_y[9], 1);

    run_job(0, 7, 1'b0, 1'b0);
    check("lit_0x7_done", seen_done, 1);
    check("lit_0x7_reads", n_rd, 0);

    run_job(31, 31, 1'b0, 1'b0);
    check("lit_31_last_z", last_wz, 60);
    check("lit_31_reads", n_rd, 961);

    // Mid-job start pulse and size change must be ignored.
    run_job(3, 5, 1'b0, 1'b1);

    // Back-to-back: second start lands in the cycle right after done.
    run_job(2, 2, 1'b0, 1'b0);
    run_job(3, 1, 1'b0, 1'b0);

    // Asynchronous reset during the first READ of k=3.
    prep(4, 4, 1'b1);
    sz_x_i = 5'd4;
    sz_y_i = 5'd4;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 0;
    job_active = 1'b1;
    for (int n = 0; n < 200 && n_rd < 7; n++) begin
      @(negedge clk); #2;
    end
    check("reached_k3", n_rd, 7);
    check("pre_reset_addr_y", int'(addr_y_o), 3);
    rstn = 1'b0;
    #1;
    check("async_rst_strobes", int'({busy_o, rd_o, wr_z_o, done_o, acc_en_o, acc_clr_o}), 0);
    check("async_rst_addrs", int'({addr_x_o, addr_y_o, addr_z_o}), 0);
    job_active = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_job(2, 3, 1'b0, 1'b0);
    check("post_reset_first_z", log_x[0] + log_y[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
